// File: rtl/credit_link_pkg.sv
// Shared types for both ends of the credit-based link.
// The credit counter width is derived here so the tx and rx sides size it the same way.
package credit_link_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } credit_tx_state_e;

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit up/down counter; resets full, saturates at CREDITS and flags a surplus return.
// Latency: count updates one edge after dec/inc; count_next_o is the combinational next value.
// Backpressure: none; the caller must never decrement at zero.
module credit_counter
    import credit_link_pkg::*;
#(
    parameter  int CREDITS = 3,
    localparam int CW      = credit_width(CREDITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc_i && !dec_i) begin
            // A return with every credit already home is a receiver bug; hold at full.
            if (count_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end else if (dec_i && !inc_i) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FULL;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/credit_link_tx.sv
// Credit-based link transmitter with drain handshake for quiescing before reconfiguration.
// Latency: a beat accepted at edge N is on the link for exactly the cycle after edge N.
// Backpressure: ready = RUN state and a credit in hand; derived from registered state only.
module credit_link_tx
    import credit_link_pkg::*;
#(
    parameter  int DATA_WIDTH   = 64,
    parameter  int CREDITS      = 3,
    localparam int CREDIT_WIDTH = credit_width(CREDITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i__data_in_valid,
    input  logic [DATA_WIDTH-1:0]   i__data_in,
    output logic                    o__data_in_ready,
    output logic                    o__link_valid,
    output logic [DATA_WIDTH-1:0]   o__link_data,
    input  logic                    i__credit_return,
    input  logic                    i__drain_req,
    output logic                    o__drained,
    output logic [CREDIT_WIDTH-1:0] o__credit_count,
    output logic                    o__err_overflow
);

    logic                    xfer;
    logic                    credits_home;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    credit_tx_state_e        state_q;
    logic                    drained_q;
    logic                    link_vld_q;
    logic [DATA_WIDTH-1:0]   link_dat_q;

    credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit_counter (
        .clk          (clk),
        .rst_n        (reset),
        .dec_i        (xfer),
        .inc_i        (i__credit_return),
        .count_o      (credit_q),
        .count_next_o (credit_d),
        .overflow_o   (o__err_overflow)
    );

    assign o__data_in_ready = (state_q == RUN) && (credit_q != '0);
    assign xfer             = i__data_in_valid && o__data_in_ready;
    // Quiescent next cycle: every credit back and nothing left on the wire.
    assign credits_home     = (credit_d == CREDIT_WIDTH'(CREDITS)) && !xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            drained_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (i__drain_req) begin
                        if (credits_home) begin
                            state_q   <= DRAINED;
                            drained_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!i__drain_req) begin
                        state_q <= RUN;
                    end else if (credits_home) begin
                        state_q   <= DRAINED;
                        drained_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!i__drain_req) begin
                        state_q   <= RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link_vld_q <= 1'b0;
            link_dat_q <= '0;
        end else begin
            link_vld_q <= xfer;
            if (xfer) begin
                link_dat_q <= i__data_in;
            end
        end
    end

    assign o__link_valid   = link_vld_q;
    assign o__link_data    = link_dat_q;
    assign o__drained      = drained_q;
    assign o__credit_count = credit_q;

endmodule

// File: tb/tb_credit_link_tx.sv
// Bench for credit_link_tx: expected link beats are queued as stimulus is issued and
// popped by an independent link monitor; control/status outputs are checked at fixed points.
module tb_credit_link_tx;

    localparam int DW = 64;
    localparam int CR = 3;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          i__data_in_valid;
    logic [DW-1:0] i__data_in;
    logic          o__data_in_ready;
    logic          o__link_valid;
    logic [DW-1:0] o__link_data;
    logic          i__credit_return;
    logic          i__drain_req;
    logic          o__drained;
    logic [CW-1:0] o__credit_count;
    logic          o__err_overflow;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    credit_link_tx #(
        .DATA_WIDTH (DW),
        .CREDITS    (CR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i__data_in_valid (i__data_in_valid),
        .i__data_in       (i__data_in),
        .o__data_in_ready (o__data_in_ready),
        .o__link_valid    (o__link_valid),
        .o__link_data     (o__link_data),
        .i__credit_return (i__credit_return),
        .i__drain_req     (i__drain_req),
        .o__drained       (o__drained),
        .o__credit_count  (o__credit_count),
        .o__err_overflow  (o__err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d);
        i__data_in_valid = 1'b1;
        i__data_in       = d;
        exp_q.push_back(d);
    endtask

    // Link monitor: every valid link cycle must match the oldest expected beat.
    always @(negedge clk) begin
        if (o__link_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL link_unexpected: got beat %0h expected no beat", o__link_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (o__link_data !== e) begin
                    errors++;
                    $display("FAIL link_data: got %0h expected %0h", o__link_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        i__data_in_valid = 1'b0;
        i__data_in       = '0;
        i__credit_return = 1'b0;
        i__drain_req     = 1'b0;
        step();
        step();
        chk("rst_link_valid", DW'(o__link_valid), 0);
        chk("rst_link_data", o__link_data, 0);
        reset = 1'b1;
        step();
        chk("rst_ready", DW'(o__data_in_ready), 1);
        chk("rst_count", DW'(o__credit_count), 3);
        chk("rst_drained", DW'(o__drained), 0);
        chk("rst_ovf", DW'(o__err_overflow), 0);

        // Three back-to-back beats exhaust the credits.
        send(64'hA); step();
        send(64'hB); step();
        send(64'hC); step();
        chk("burst_count", DW'(o__credit_count), 0);
        chk("burst_ready", DW'(o__data_in_ready), 0);

        // Starved with valid held: one returned credit lets exactly one beat through.
        i__data_in = 64'hD;
        step();
        chk("starved_count", DW'(o__credit_count), 0);
        i__credit_return = 1'b1;
        step();
        i__credit_return = 1'b0;
        chk("one_credit_count", DW'(o__credit_count), 1);
        chk("one_credit_ready", DW'(o__data_in_ready), 1);
        exp_q.push_back(64'hD);
        step();
        chk("one_beat_count", DW'(o__credit_count), 0);
        step();
        chk("one_beat_ready", DW'(o__data_in_ready), 0);
        i__data_in_valid = 1'b0;

        // Single credit with simultaneous send and return sustains full rate.
        i__credit_return = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            send(64'h100 + DW'(i));
            step();
            chk("stream_count", DW'(o__credit_count), 1);
        end
        i__data_in_valid = 1'b0;
        step();
        step();
        i__credit_return = 1'b0;
        chk("refill_count", DW'(o__credit_count), 3);

        // Drain with two beats outstanding; the beat on the request edge is still taken.
        send(64'hE0); step();
        send(64'hE1); i__drain_req = 1'b1; step();
        chk("drain_ready", DW'(o__data_in_ready), 0);
        chk("drain_count", DW'(o__credit_count), 1);
        chk("drain_not_done", DW'(o__drained), 0);
        i__data_in      = 64'hBAD;
        i__credit_return = 1'b1; step();
        i__credit_return = 1'b0; step();
        chk("drain_one_back", DW'(o__drained), 0);
        chk("drain_one_count", DW'(o__credit_count), 2);
        i__credit_return = 1'b1; step();
        i__credit_return = 1'b0;
        chk("drained_rise", DW'(o__drained), 1);
        chk("drained_count", DW'(o__credit_count), 3);
        step();
        chk("drained_hold", DW'(o__drained), 1);
        chk("drained_ready", DW'(o__data_in_ready), 0);
        i__drain_req     = 1'b0;
        i__data_in_valid = 1'b0;
        step();
        chk("undrain_drained", DW'(o__drained), 0);
        chk("undrain_ready", DW'(o__data_in_ready), 1);

        // Idle drain at full credits completes in one cycle.
        i__drain_req = 1'b1; step();
        chk("idle_drained", DW'(o__drained), 1);
        i__drain_req = 1'b0; step();
        chk("idle_undrain", DW'(o__data_in_ready), 1);

        // Surplus credit return at full credits.
        i__credit_return = 1'b1; step();
        i__credit_return = 1'b0;
        chk("ovf_set", DW'(o__err_overflow), 1);
        chk("ovf_count", DW'(o__credit_count), 3);
        step(); step();
        chk("ovf_sticky", DW'(o__err_overflow), 1);

        // Reset asserted mid-stream with two credits outstanding.
        send(64'hF0); step();
        send(64'hF1); step();
        i__data_in_valid = 1'b0;
        chk("pre_reset_count", DW'(o__credit_count), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_link_valid", DW'(o__link_valid), 0);
        chk("mid_reset_count", DW'(o__credit_count), 3);
        chk("mid_reset_ovf", DW'(o__err_overflow), 0);
        step();
        reset = 1'b1;
        step();
        chk("post_reset_count", DW'(o__credit_count), 3);
        chk("post_reset_ready", DW'(o__data_in_ready), 1);
        chk("post_reset_link_valid", DW'(o__link_valid), 0);
        step();
        chk("beats_outstanding", DW'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/credit_link_tx.md
# credit_link_tx

Transmitting end of a credit-based link whose receiver is a `fifo` instance of depth `CREDITS`.
- Accepts beats from a local valid/ready producer, registers them, and drives them onto a link that has no ready signal.
- Counts one credit per free receiver entry, so the receiving FIFO can never overflow.
- Provides a drain handshake that waits until every credit has returned, so the sender can be quiesced before the link is reconfigured.

## Interface
Parameters:
- `DATA_WIDTH`, 64, beat width.
- `CREDITS`, 3, receiver FIFO depth; initial credit count.
- `CREDIT_WIDTH`, `$clog2(CREDITS+1)`, credit counter width (local constant).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset: asserts asynchronously on 0, deasserts synchronously to `clk`.
- `i__data_in_valid`  in  1  producer has a beat.
- `i__data_in`  in  DATA_WIDTH  producer beat.
- `o__data_in_ready`  out  1  a beat presented this cycle is taken.
- `o__link_valid`  out  1  one beat on the link this cycle.
- `o__link_data`  out  DATA_WIDTH  link beat.
- `i__credit_return`  in  1  receiver popped one entry; returns one credit.
- `i__drain_req`  in  1  level request to quiesce.
- `o__drained`  out  1  all credits home, sender stopped.
- `o__credit_count`  out  CREDIT_WIDTH  current credits, for debug.
- `o__err_overflow`  out  1  sticky flag: a credit returned with counter full.

## Operation
- Transfer: occurs when `i__data_in_valid && o__data_in_ready`.
- Ready: `o__data_in_ready = (state==RUN) && (credit_q != 0)`.
  - Depends only on registered state; there is no combinational path from `i__data_in_valid` or `i__credit_return`.
- Credit update, every cycle: `credit_d = credit_q - xfer + i__credit_return`.
  - Simultaneous send and return leaves the count unchanged.
- Overflow:
  - A return with `credit_q == CREDITS` and no send in the same cycle sets `o__err_overflow`.
  - In that case the counter saturates at `CREDITS`.
  - The flag clears only on reset.
- Underflow is impossible by construction, because ready requires `credit_q != 0`.
- Link register: `o__link_valid <= xfer`; `o__link_data <= i__data_in` on xfer, else held.
- FSM states: RUN, DRAIN, DRAINED.
  - RUN → DRAIN when `i__drain_req` is high. Ready is low from the next cycle onward.
  - DRAIN → DRAINED when `credit_d == CREDITS` and `o__link_valid` is low next cycle.
  - DRAINED: `o__drained` is high, registered.
  - DRAINED → RUN when `i__drain_req` is low.
  - DRAIN → RUN if `i__drain_req` drops before credits are complete; credits keep counting.
- A transfer on the same cycle `i__drain_req` rises is still accepted (ready is registered-state based).
- Reset values:
  - `credit_q = CREDITS`, state RUN.
  - `o__link_valid = 0`, `o__link_data = 0`.
  - `o__drained = 0`, `o__err_overflow = 0`.
  - Therefore `o__data_in_ready = 1` after reset.
- Reset mid-operation: the counter and FSM return immediately to their reset values. The receiving FIFO must be reset in the same domain event.

## Timing
- Latency: a beat accepted at edge N appears on `o__link_valid` / `o__link_data` in cycle N+1, for exactly one cycle.
- Throughput: 1 beat/cycle while credits remain.
  - Sustained full rate requires `CREDITS` ≥ link round trip (send → receiver pop → credit back).
- A credit returned at edge N is usable for a send at edge N+1.
- Drain: the minimum time from `i__drain_req` rising to `o__drained` is 1 cycle when idle with full credits. Otherwise it is the cycle after the last credit returns.

## Structure
- Shared package `credit_link_pkg`:
  - `credit_tx_state_e` {RUN, DRAIN, DRAINED}.
  - Localparam helper for `CREDIT_WIDTH`.
  - The receiver side (`credit_link_rx`, a later block) imports the same package.
- Sub-module `credit_counter` (parameterised by `CREDITS`): up/down counter with saturation and overflow flag, reusable by the receiver.
- The FSM and link register live in the top module.

## Test plan
- Reset, then stream 3 beats 0xA,0xB,0xC back-to-back with `CREDITS=3` and no returns:
  - all accepted; link carries 0xA,0xB,0xC on cycles 1–3;
  - ready drops after the third beat; `o__credit_count=0`.
- With credits=0 and valid held high, pulse `i__credit_return` once:
  - exactly one beat accepted on the following edge;
  - count returns to 0.
- With 1 credit, send and return in the same cycle:
  - count stays 1; continuous 1 beat/cycle for 10 cycles.
- After 2 outstanding beats, assert `i__drain_req`:
  - ready low next cycle;
  - `o__drained` rises the cycle after the second credit returns;
  - dropping the request restores ready.
- At full credits, pulse `i__credit_return` with no send:
  - `o__err_overflow=1` and stays high;
  - count stays 3.
- Assert `reset` low mid-stream with 2 credits out:
  - `o__link_valid=0` immediately;
  - after release, count=3 and ready=1.
